// File: rtl/mainfsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mainfsm: multi-cycle control-unit sequencer (fetch/decode/exec/mem/wb).  |
// | Optional long-multiply high-half write enabled by MAINFSM_MULL_EN.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mainfsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       Mull,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       NextPC,
  output logic       Branch,
  output logic       RegW,
  output logic       MemW,
  output logic       RegWHi,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_t;

  state_t     state_q, state_d;
  logic       fetch_q, fetch_d;
  logic       alu_wb_q, alu_wb_d;
  logic       adr_src_q, adr_src_d;
  logic [1:0] alu_src_a_q, alu_src_a_d;
  logic [1:0] alu_src_b_q, alu_src_b_d;
  logic [1:0] result_src_q, result_src_d;
  logic       alu_op_q, alu_op_d;
  logic       reg_w_q, reg_w_d;
  logic       mem_w_q, mem_w_d;
  logic       branch_q, branch_d;
  logic       illegal_q, illegal_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (MemReady) state_d = DECODE;
      DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR:   state_d = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    if (MemReady) state_d = MEMWB;
      MEMWR:    if (MemReady) state_d = FETCH;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      MEMWB:    state_d = FETCH;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      default:  state_d = UNKNOWN;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the state register they describe.
  always_comb begin
    fetch_d      = 1'b0;
    alu_wb_d     = 1'b0;
    adr_src_d    = 1'b0;
    alu_src_a_d  = 2'b00;
    alu_src_b_d  = 2'b00;
    result_src_d = 2'b00;
    alu_op_d     = 1'b0;
    reg_w_d      = 1'b0;
    mem_w_d      = 1'b0;
    branch_d     = 1'b0;
    illegal_d    = 1'b0;
    case (state_d)
      FETCH: begin
        fetch_d      = 1'b1;
        alu_src_a_d  = 2'b01;
        alu_src_b_d  = 2'b10;
        result_src_d = 2'b10;
      end
      DECODE: begin
        alu_src_a_d  = 2'b01;
        alu_src_b_d  = 2'b10;
        result_src_d = 2'b10;
      end
      MEMADR:   alu_src_b_d = 2'b01;
      MEMRD:    adr_src_d   = 1'b1;
      MEMWB: begin
        result_src_d = 2'b01;
        reg_w_d      = 1'b1;
      end
      MEMWR: begin
        adr_src_d = 1'b1;
        mem_w_d   = 1'b1;
      end
      EXECUTER: alu_op_d = 1'b1;
      EXECUTEI: begin
        alu_src_b_d = 2'b01;
        alu_op_d    = 1'b1;
      end
      ALUWB: begin
        reg_w_d  = 1'b1;
        alu_wb_d = 1'b1;
      end
      BRANCH: begin
        alu_src_b_d  = 2'b01;
        result_src_d = 2'b10;
        branch_d     = 1'b1;
      end
      default:  illegal_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FETCH;
      fetch_q      <= 1'b1;
      alu_wb_q     <= 1'b0;
      adr_src_q    <= 1'b0;
      alu_src_a_q  <= 2'b01;
      alu_src_b_q  <= 2'b10;
      result_src_q <= 2'b10;
      alu_op_q     <= 1'b0;
      reg_w_q      <= 1'b0;
      mem_w_q      <= 1'b0;
      branch_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_q      <= fetch_d;
      alu_wb_q     <= alu_wb_d;
      adr_src_q    <= adr_src_d;
      alu_src_a_q  <= alu_src_a_d;
      alu_src_b_q  <= alu_src_b_d;
      result_src_q <= result_src_d;
      alu_op_q     <= alu_op_d;
      reg_w_q      <= reg_w_d;
      mem_w_q      <= mem_w_d;
      branch_q     <= branch_d;
      illegal_q    <= illegal_d;
    end
  end

  // Fetch strobes follow the memory handshake and are held off during reset.
  assign IRWrite   = fetch_q & MemReady & reset;
  assign NextPC    = fetch_q & MemReady & reset;
  assign AdrSrc    = adr_src_q;
  assign ALUSrcA   = alu_src_a_q;
  assign ALUSrcB   = alu_src_b_q;
  assign ResultSrc = result_src_q;
  assign ALUOp     = alu_op_q;
  assign RegW      = reg_w_q;
  assign MemW      = mem_w_q;
  assign Branch    = branch_q;
  assign Illegal   = illegal_q;
  assign State     = state_q;

`ifdef MAINFSM_MULL_EN
  assign RegWHi = alu_wb_q & Mull;
  logic unused_bits;
  assign unused_bits = &{1'b0, Funct[4:1]};
`else
  assign RegWHi = 1'b0;
  logic unused_bits;
  assign unused_bits = &{1'b0, Funct[4:1], Mull, alu_wb_q};
`endif

endmodule
`default_nettype wire

// File: tb/tb_mainfsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mainfsm: table-driven self-checking bench for mainfsm.                |
// | Expected RegWHi depends on MAINFSM_MULL_EN.                              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mainfsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] op = 2'b00;
  logic [5:0] funct = 6'd0;
  logic       mull = 1'b0;
  logic       mem_ready = 1'b1;
  logic       ir_write, adr_src, alu_op, next_pc, branch, reg_w, mem_w, reg_w_hi, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  mainfsm dut (
    .clk(clk), .reset(rst_n), .Op(op), .Funct(funct), .Mull(mull), .MemReady(mem_ready),
    .IRWrite(ir_write), .AdrSrc(adr_src), .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b),
    .ResultSrc(result_src), .ALUOp(alu_op), .NextPC(next_pc), .Branch(branch),
    .RegW(reg_w), .MemW(mem_w), .RegWHi(reg_w_hi), .Illegal(illegal), .State(state)
  );

  always #5 clk = ~clk;

  // Strobes: {IRWrite, NextPC, RegW, MemW, RegWHi, Branch, Illegal}
  localparam logic [6:0] S_NONE  = 7'b0000000;
  localparam logic [6:0] S_FETCH = 7'b1100000;
  localparam logic [6:0] S_REGW  = 7'b0010000;
  localparam logic [6:0] S_MEMW  = 7'b0001000;
  localparam logic [6:0] S_BR    = 7'b0000010;
  localparam logic [6:0] S_ILL   = 7'b0000001;
`ifdef MAINFSM_MULL_EN
  localparam logic [6:0] S_MULL  = 7'b0010100;
`else
  localparam logic [6:0] S_MULL  = 7'b0010000;
`endif
  // Selects: {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp}
  localparam logic [7:0] SEL_F  = 8'b0_01_10_10_0;
  localparam logic [7:0] SEL_0  = 8'b0_00_00_00_0;
  localparam logic [7:0] SEL_ER = 8'b0_00_00_00_1;
  localparam logic [7:0] SEL_EI = 8'b0_00_01_00_1;
  localparam logic [7:0] SEL_MA = 8'b0_00_01_00_0;
  localparam logic [7:0] SEL_MR = 8'b1_00_00_00_0;
  localparam logic [7:0] SEL_WB = 8'b0_00_00_01_0;
  localparam logic [7:0] SEL_BR = 8'b0_00_01_10_0;

  typedef struct {
    logic       rst_n;
    logic [1:0] op;
    logic [5:0] funct;
    logic       mull;
    logic       mr;
    logic [3:0] st;
    logic [6:0] strb;
    logic [7:0] sel;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [1:0] o, logic [5:0] f, logic m, logic mr,
                              logic [3:0] st, logic [6:0] strb, logic [7:0] sel);
    vec_t v;
    v.rst_n = r; v.op = o; v.funct = f; v.mull = m; v.mr = mr;
    v.st = st; v.strb = strb; v.sel = sel;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [6:0] strobes();
    return {ir_write, next_pc, reg_w, mem_w, reg_w_hi, branch, illegal};
  endfunction

  function automatic logic [7:0] selects();
    return {adr_src, alu_src_a, alu_src_b, result_src, alu_op};
  endfunction

  initial begin
    // Reset held for three cycles
    repeat (3) vecs.push_back(mk(0, 2'b00, 6'd0, 0, 1, 4'd0, S_NONE, SEL_F));
    // Data-processing register; MemReady low in DECODE is ignored
    vecs.push_back(mk(1, 2'b00, 6'b000000, 0, 1, 4'd0, S_FETCH, SEL_F));
    vecs.push_back(mk(1, 2'b00, 6'b000000, 0, 0, 4'd1, S_NONE,  SEL_F));
    vecs.push_back(mk(1, 2'b00, 6'b000000, 0, 1, 4'd6, S_NONE,  SEL_ER));
    vecs.push_back(mk(1, 2'b00, 6'b000000, 0, 1, 4'd8, S_REGW,  SEL_0));
    // Fetch stall, then load with two MEMRD stall cycles
    vecs.push_back(mk(1, 2'b01, 6'b000001, 0, 0, 4'd0, S_NONE,  SEL_F));
    vecs.push_back(mk(1, 2'b01, 6'b000001, 0, 1, 4'd0, S_FETCH, SEL_F));
    vecs.push_back(mk(1, 2'b01, 6'b000001, 0, 1, 4'd1, S_NONE,  SEL_F));
    vecs.push_back(mk(1, 2'b01, 6'b000001, 0, 1, 4'd2, S_NONE,  SEL_MA));
    vecs.push_back(mk(1, 2'b01, 6'b000001, 0, 0, 4'd3, S_NONE,  SEL_MR));
    vecs.push_back(mk(1, 2'b01, 6'b000001, 0, 0, 4'd3, S_NONE,  SEL_MR));
    vecs.push_back(mk(1, 2'b01, 6'b000001, 0, 1, 4'd3, S_NONE,  SEL_MR));
    vecs.push_back(mk(1, 2'b01, 6'b000001, 0, 1, 4'd4, S_REGW,  SEL_WB));
    // Store with one MEMWR stall cycle
    vecs.push_back(mk(1, 2'b01, 6'b000000, 0, 1, 4'd0, S_FETCH, SEL_F));
    vecs.push_back(mk(1, 2'b01, 6'b000000, 0, 1, 4'd1, S_NONE,  SEL_F));
    vecs.push_back(mk(1, 2'b01, 6'b000000, 0, 1, 4'd2, S_NONE,  SEL_MA));
    vecs.push_back(mk(1, 2'b01, 6'b000000, 0, 0, 4'd5, S_MEMW,  SEL_MR));
    vecs.push_back(mk(1, 2'b01, 6'b000000, 0, 1, 4'd5, S_MEMW,  SEL_MR));
    // Immediate long multiply
    vecs.push_back(mk(1, 2'b00, 6'b100000, 1, 1, 4'd0, S_FETCH, SEL_F));
    vecs.push_back(mk(1, 2'b00, 6'b100000, 1, 1, 4'd1, S_NONE,  SEL_F));
    vecs.push_back(mk(1, 2'b00, 6'b100000, 1, 1, 4'd7, S_NONE,  SEL_EI));
    vecs.push_back(mk(1, 2'b00, 6'b100000, 1, 1, 4'd8, S_MULL,  SEL_0));
    // Branch
    vecs.push_back(mk(1, 2'b10, 6'b000000, 0, 1, 4'd0, S_FETCH, SEL_F));
    vecs.push_back(mk(1, 2'b10, 6'b000000, 0, 1, 4'd1, S_NONE,  SEL_F));
    vecs.push_back(mk(1, 2'b10, 6'b000000, 0, 1, 4'd9, S_BR,    SEL_BR));
    // Undefined opcode: sticky until reset
    vecs.push_back(mk(1, 2'b11, 6'b000000, 0, 1, 4'd0, S_FETCH, SEL_F));
    vecs.push_back(mk(1, 2'b11, 6'b000000, 0, 1, 4'd1, S_NONE,  SEL_F));
    vecs.push_back(mk(1, 2'b11, 6'b000000, 0, 1, 4'd10, S_ILL,  SEL_0));
    vecs.push_back(mk(1, 2'b00, 6'b000000, 0, 0, 4'd10, S_ILL,  SEL_0));
    vecs.push_back(mk(1, 2'b01, 6'b000001, 0, 1, 4'd10, S_ILL,  SEL_0));
    vecs.push_back(mk(0, 2'b00, 6'b000000, 0, 1, 4'd0, S_NONE,  SEL_F));
    vecs.push_back(mk(0, 2'b00, 6'b000000, 0, 1, 4'd0, S_NONE,  SEL_F));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; op = vecs[i].op; funct = vecs[i].funct;
      mull = vecs[i].mull; mem_ready = vecs[i].mr;
      #1;
      chk($sformatf("row%0d_state", i), {28'd0, state}, {28'd0, vecs[i].st});
      chk($sformatf("row%0d_strobes", i), {25'd0, strobes()}, {25'd0, vecs[i].strb});
      chk($sformatf("row%0d_selects", i), {24'd0, selects()}, {24'd0, vecs[i].sel});
    end

    // Asynchronous reset while a store is stalled in MEMWR
    @(negedge clk);
    rst_n = 1'b1; op = 2'b01; funct = 6'd0; mull = 1'b0; mem_ready = 1'b1;
    #1;
    chk("abort_fetch_irwrite", {31'd0, ir_write}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_pre_state", {28'd0, state}, 32'd5);
    chk("abort_pre_memw", {31'd0, mem_w}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_state", {28'd0, state}, 32'd0);
    chk("abort_strobes", {25'd0, strobes()}, 32'd0);
    chk("abort_selects", {24'd0, selects()}, {24'd0, SEL_F});
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_stall_irwrite", {31'd0, ir_write}, 32'd0);
    @(negedge clk);
    #1;
    chk("release_stall_state", {28'd0, state}, 32'd0);
    chk("release_stall_memw", {31'd0, mem_w}, 32'd0);
    mem_ready = 1'b1;
    #1;
    chk("release_go_nextpc", {31'd0, next_pc}, 32'd1);
    @(negedge clk);
    #1;
    chk("release_go_state", {28'd0, state}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
